keypad_decoder: RTL and testbench
=================================

KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: clk cycles waited after a row change before columns are sampled; legal range 1..255.
REQ-002 Parameter DEBOUNCE_SCANS, default 3: consecutive differing samples needed to change a key's stable state; legal range 1..7.
REQ-003 Parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 row  input  4  one-hot row strobe from the scanner; bit r high means row r is driven.
REQ-007 col  input  4  column sense lines, synchronous to clk; bit c high means key (row, c) is closed.
REQ-008 matrix  output  16  debounced key state; bit 4*r+c is key (r, c).
REQ-009 any_key  output  1  OR of matrix.
REQ-010 evt_valid  output  1  event FIFO non-empty.
REQ-011 evt_ready  input  1  consumer accepts the head event when evt_valid and evt_ready are both high.
REQ-012 evt_key  output  4  key code 4*r+c of the head event.
REQ-013 evt_press  output  1  1 = press, 0 = release, for the head event.
REQ-014 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-015 bad_row  output  1  sticky; row was seen non-one-hot and non-zero.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, UPDATE.
REQ-017 The block SHALL register row every cycle; a row change is a cycle in which row differs from its previous registered value.
REQ-018 IDLE: on a row change to a one-hot value, go to SETTLE and load the settle counter with SETTLE_CYCLES.
REQ-019 SETTLE: decrement each cycle; a row change restarts SETTLE for the new row if it is one-hot, otherwise returns to IDLE; at count 0, latch col and the row index, then go to UPDATE.
REQ-020 UPDATE: process columns 0..3 over four consecutive cycles, one key per cycle, then return to IDLE; row changes during UPDATE are ignored except for setting bad_row.
REQ-021 Per-key processing: if sample equals stable bit, clear that key's 3-bit debounce count; otherwise increment it, and when it reaches DEBOUNCE_SCANS, toggle the stable bit, clear the count and push an event {key, new state}.
REQ-022 A row of 0 SHALL cause no sampling; a multi-hot row SHALL cause no sampling and set bad_row.
REQ-023 matrix SHALL update in the same cycle a key's stable bit toggles, regardless of FIFO state.
REQ-024 FIFO: first-in first-out; evt_key and evt_press SHALL be driven from the head entry; they are don't-care when evt_valid is 0.
REQ-025 Push when full with no pop: the event SHALL be dropped and overflow set.
REQ-026 Push and pop in the same cycle when full: both SHALL occur, and the FIFO SHALL stay full with no overflow.
REQ-027 Push and pop in the same cycle when empty: the event SHALL be accepted, and evt_valid SHALL be high the next cycle.
REQ-028 Counters and pointers SHALL wrap modulo their width; the occupancy counter SHALL never exceed FIFO_DEPTH.
REQ-029 Latency: an event SHALL appear on evt_valid at most 1 cycle after the UPDATE cycle that generated it.

Reset
REQ-030 Reset SHALL be asynchronous, active-low, and take effect immediately, including mid-SETTLE or mid-UPDATE.
REQ-031 While rst_n is low: FSM = IDLE, registered row = 0, matrix = 0, any_key = 0, all debounce counts = 0, FIFO empty, evt_valid = 0, overflow = 0, bad_row = 0.
REQ-032 After rst_n deasserts, the first nonzero one-hot row SHALL count as a row change.

Verification
REQ-033 Defaults; hold col=4'b0100 while cycling row 0001,0010,0100,1000 with 64-cycle phases -> after the 3rd row-0 scan, matrix = 16'h0004, one event {key 2, press}, any_key = 1.
REQ-034 Key (1,3) held for 2 scans, then released -> no event, matrix stays 0.
REQ-035 Press 12 distinct keys with evt_ready = 0 -> 8 events queued in order, overflow = 1, matrix shows all 12 keys; then evt_ready = 1 -> exactly 8 pops, then evt_valid = 0.
REQ-036 FIFO full, push and pop in the same cycle -> occupancy stays 8, overflow stays 0, head advances.
REQ-037 row = 0011 -> bad_row = 1, no sampling, matrix unchanged; row change 2 cycles into SETTLE -> SETTLE restarts, only the new row is sampled.
REQ-038 rst_n pulsed low during UPDATE with 3 events queued -> outputs reach reset values with no clk edge; after release, the next full press sequence produces a fresh press event.

Source files
------------

// File: rtl/keypad_decoder.sv
// 4x4 keypad matrix decoder: samples columns once per settled row strobe,
// debounces each key over several scans and queues press/release events.
module keypad_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] matrix,
  output logic        any_key,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_press,
  output logic        overflow,
  output logic        bad_row
);

  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [2:0]  DB_LAST     = 3'(DEBOUNCE_SCANS - 1);
  localparam logic [PW:0] DEPTH_C     = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, UPDATE} state_t;

  state_t        state, state_d;
  logic [3:0]    row_q;
  logic          row_chg, row_onehot, row_multi;
  logic [7:0]    settle_cnt;
  logic [1:0]    col_idx, row_idx;
  logic [3:0]    col_lat;
  logic          settle_load, settle_dec, sample_en, upd;

  logic [15:0]   stable;
  logic [2:0]    dcnt [16];
  logic [3:0]    key;
  logic          sample, push, pop, push_acc, full;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    onehot_idx = 2'd0;
    if (v[1]) onehot_idx = 2'd1;
    if (v[2]) onehot_idx = 2'd2;
    if (v[3]) onehot_idx = 2'd3;
  endfunction

  assign row_chg    = (row != row_q);
  assign row_onehot = (row != 4'd0) && ((row & (row - 4'd1)) == 4'd0);
  assign row_multi  = (row != 4'd0) && !row_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (row_chg && row_onehot) state_d = SETTLE;
      SETTLE: begin
        if (row_chg)                state_d = row_onehot ? SETTLE : IDLE;
        else if (settle_cnt == '0)  state_d = UPDATE;
      end
      UPDATE:  if (col_idx == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    sample_en   = 1'b0;
    upd         = 1'b0;
    case (state)
      IDLE:   settle_load = row_chg && row_onehot;
      SETTLE: begin
        if (row_chg)               settle_load = row_onehot;
        else if (settle_cnt == '0) sample_en   = 1'b1;
        else                       settle_dec  = 1'b1;
      end
      UPDATE: upd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      settle_cnt <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      col_lat    <= '0;
      bad_row    <= 1'b0;
    end else begin
      row_q <= row;
      if (row_multi) bad_row <= 1'b1;
      if (settle_load)     settle_cnt <= SETTLE_LOAD;
      else if (settle_dec) settle_cnt <= settle_cnt - 8'd1;
      if (sample_en) begin
        col_lat <= col;
        row_idx <= onehot_idx(row);
        col_idx <= '0;
      end else if (upd) begin
        col_idx <= col_idx + 2'd1;
      end
    end
  end

  // One key per UPDATE cycle; the event is generated in the same cycle the
  // stable bit toggles, so matrix never waits on FIFO space.
  assign key    = {row_idx, col_idx};
  assign sample = col_lat[col_idx];
  assign push   = upd && (sample != stable[key]) && (dcnt[key] == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < 16; i++) dcnt[i] <= '0;
    end else if (upd) begin
      if (sample == stable[key]) begin
        dcnt[key] <= '0;
      end else if (dcnt[key] == DB_LAST) begin
        stable[key] <= ~stable[key];
        dcnt[key]   <= '0;
      end else begin
        dcnt[key] <= dcnt[key] + 3'd1;
      end
    end
  end

  assign pop      = evt_valid && evt_ready;
  assign full     = (count == DEPTH_C);
  assign push_acc = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= {key, ~stable[key]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign matrix    = stable;
  assign any_key   = |stable;
  assign evt_valid = (count != '0);
  assign evt_key   = mem[rd_ptr][4:1];
  assign evt_press = mem[rd_ptr][0];

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder: a per-scan keypad model predicts events
// and debounced state; a negedge monitor checks every accepted event in order.
module tb_keypad_decoder;

  localparam int unsigned SC = 16;
  localparam int unsigned DB = 3;
  localparam int unsigned FD = 8;
  localparam int          LONG_MIN = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row = '0;
  logic [3:0]  col = '0;
  logic [15:0] matrix;
  logic        any_key, evt_valid, evt_press, overflow, bad_row;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_key;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [4:0] sb[$];
  logic [4:0] mon_e;
  bit         mstable [16];
  int         mcnt [16];
  bit         exp_ovf, exp_bad, cap;
  logic [3:0] prev_row;
  logic [3:0] pat [4];

  keypad_decoder #(
    .SETTLE_CYCLES (SC),
    .DEBOUNCE_SCANS(DB),
    .FIFO_DEPTH    (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .matrix    (matrix),
    .any_key   (any_key),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_press (evt_press),
    .overflow  (overflow),
    .bad_row   (bad_row)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepted events are compared against the oldest predicted event.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got key %0d press %0b expected no event", evt_key, evt_press);
      end else begin
        mon_e = sb.pop_front();
        check("evt_head", {27'd0, evt_key, evt_press}, {27'd0, mon_e});
      end
    end
  end

  function automatic logic [15:0] model_matrix();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = mstable[i];
    return m;
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      mstable[i] = 1'b0;
      mcnt[i]    = 0;
    end
    exp_ovf  = 1'b0;
    exp_bad  = 1'b0;
    prev_row = 4'd0;
  endtask

  // A long, one-hot phase on a new row yields one scan of that row's columns.
  task automatic model_sample(input logic [3:0] r, input logic [3:0] c, input int len);
    int ri;
    int k;
    if (r != 4'd0 && $countones(r) != 1) exp_bad = 1'b1;
    if ($countones(r) == 1 && r != prev_row && len >= LONG_MIN) begin
      ri = 0;
      for (int i = 0; i < 4; i++) if (r[i]) ri = i;
      for (int c_i = 0; c_i < 4; c_i++) begin
        k = ri * 4 + c_i;
        if (c[c_i] == mstable[k]) begin
          mcnt[k] = 0;
        end else begin
          mcnt[k]++;
          if (mcnt[k] == DB) begin
            mstable[k] = ~mstable[k];
            mcnt[k]    = 0;
            if (cap && sb.size() >= FD) exp_ovf = 1'b1;
            else sb.push_back({4'(k), mstable[k]});
          end
        end
      end
    end
    prev_row = r;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] c, input int len);
    row = r;
    col = c;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input logic [3:0] r, input logic [3:0] c, input int len);
    model_sample(r, c, len);
    drive(r, c, len);
  endtask

  task automatic check_state(input string tag);
    logic [15:0] mm;
    mm = model_matrix();
    check({tag, "_matrix"},   {16'd0, matrix}, {16'd0, mm});
    check({tag, "_any_key"},  {31'd0, any_key}, {31'd0, |mm});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_bad_row"},  {31'd0, bad_row}, {31'd0, exp_bad});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    row   = '0;
    col   = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_matrix",    {16'd0, matrix}, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_overflow",  {31'd0, overflow}, 32'd0);
    check("rst_bad_row",   {31'd0, bad_row}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    bit found;
    logic [3:0] r;
    logic [3:0] c;
    int len, ri, kind;

    cap = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Constant column 2 across all rows: row 0 key 2 latches on its 3rd scan.
    do_reset();
    evt_ready = 1'b1;
    p0 = pops;
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 4; i++) run_phase(4'(1 << i), 4'b0100, 64);
    run_phase(4'b0001, 4'b0100, 64);
    check("t33_matrix", {16'd0, matrix}, 32'h0004);
    check("t33_any_key", {31'd0, any_key}, 32'd1);
    check("t33_events", pops - p0, 32'd1);
    check_state("t33");

    // Key (1,3) for two scans only: no event.
    do_reset();
    evt_ready = 1'b1;
    p0 = pops;
    for (int pass = 0; pass < 5; pass++)
      for (int i = 0; i < 4; i++)
        run_phase(4'(1 << i), (pass < 2 && i == 1) ? 4'b1000 : 4'b0000, 40);
    check("t34_matrix", {16'd0, matrix}, 32'd0);
    check("t34_events", pops - p0, 32'd0);
    check_state("t34");

    // Twelve presses into a stalled consumer: first 8 kept, overflow sticky.
    do_reset();
    evt_ready = 1'b0;
    for (int pass = 0; pass < 3; pass++)
      for (int i = 0; i < 4; i++)
        run_phase(4'(1 << i), (i < 3) ? 4'b1111 : 4'b0000, 40);
    check("t35_matrix", {16'd0, matrix}, 32'h0FFF);
    check("t35_overflow", {31'd0, overflow}, 32'd1);
    check("t35_valid_full", {31'd0, evt_valid}, 32'd1);
    p0 = pops;
    evt_ready = 1'b1;
    wait_cycles(20);
    check("t35_pops", pops - p0, 32'd8);
    check("t35_valid_drained", {31'd0, evt_valid}, 32'd0);
    check_state("t35");

    // Full FIFO with a simultaneous push and pop: 7 queued, 8th push, then
    // one ready cycle aligned with the 9th push.
    do_reset();
    evt_ready = 1'b0;
    cap = 1'b0;
    pat[0] = 4'b1111; pat[1] = 4'b0111; pat[2] = 4'b0011; pat[3] = 4'b0000;
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 4; i++) run_phase(4'(1 << i), pat[i], 40);
    run_phase(4'b0001, pat[0], 40);
    run_phase(4'b0010, pat[1], 40);
    model_sample(4'b0100, pat[2], 40);
    row = 4'b0100;
    col = pat[2];
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (matrix[8]) found = 1'b1;
    end
    check("t36_first_push_seen", {31'd0, found}, 32'd1);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
    wait_cycles(30);
    check("t36_overflow", {31'd0, overflow}, 32'd0);
    check("t36_valid", {31'd0, evt_valid}, 32'd1);
    check_state("t36");
    p0 = pops;
    evt_ready = 1'b1;
    wait_cycles(20);
    check("t36_occupancy", pops - p0, 32'd8);
    check("t36_valid_drained", {31'd0, evt_valid}, 32'd0);
    check("t36_overflow_end", {31'd0, overflow}, 32'd0);
    cap = 1'b1;

    // Multi-hot row flags bad_row; a row change early in SETTLE restarts it.
    do_reset();
    evt_ready = 1'b1;
    run_phase(4'b0011, 4'b1111, 40);
    check("t37_bad_row", {31'd0, bad_row}, 32'd1);
    check("t37_matrix_unchanged", {16'd0, matrix}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      run_phase(4'b0001, 4'b1111, 2);
      run_phase(4'b0100, 4'b0001, 40);
      run_phase(4'b0000, 4'b0000, 10);
    end
    check("t37_matrix_new_row", {16'd0, matrix}, 32'h0100);
    check_state("t37");

    // Reset asserted mid-UPDATE with three events queued.
    do_reset();
    evt_ready = 1'b0;
    for (int pass = 0; pass < 3; pass++)
      for (int i = 0; i < 4; i++)
        run_phase(4'(1 << i), (i == 0) ? 4'b0111 : 4'b0000, 40);
    check("t38_queued", {31'd0, evt_valid}, 32'd1);
    row = 4'b0010;
    col = 4'b0000;
    repeat (SC + 3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t38_async_matrix",   {16'd0, matrix}, 32'd0);
    check("t38_async_any_key",  {31'd0, any_key}, 32'd0);
    check("t38_async_valid",    {31'd0, evt_valid}, 32'd0);
    check("t38_async_overflow", {31'd0, overflow}, 32'd0);
    check("t38_async_bad_row",  {31'd0, bad_row}, 32'd0);
    model_reset();
    row = 4'b0000;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pops;
    for (int pass = 0; pass < 3; pass++)
      for (int i = 0; i < 4; i++)
        run_phase(4'(1 << i), (i == 0) ? 4'b0001 : 4'b0000, 40);
    check("t38_fresh_press", pops - p0, 32'd1);
    check_state("t38");

    // Randomised phases: held key patterns, glitches, idle and bad rows.
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) pat[i] = 4'($urandom_range(0, 15));
    for (int ph = 0; ph < 60; ph++) begin
      do begin
        kind = $urandom_range(0, 9);
        if (kind == 0) r = 4'b0000;
        else if (kind == 1) begin
          do r = 4'($urandom_range(0, 15)); while ($countones(r) < 2);
        end else r = 4'(1 << $urandom_range(0, 3));
      end while (r == prev_row);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : $urandom_range(34, 50);
      if ($countones(r) == 1) begin
        ri = 0;
        for (int i = 0; i < 4; i++) if (r[i]) ri = i;
        if ($urandom_range(0, 3) == 0) pat[ri] = 4'($urandom_range(0, 15));
        c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : pat[ri];
      end else begin
        c = 4'($urandom_range(0, 15));
      end
      run_phase(r, c, len);
      check_state("rand");
    end
    run_phase(4'b0000, 4'b0000, 20);
    check("rand_drained", sb.size(), 32'd0);
    check_state("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
